// File: rtl/bp_resolve_queue.sv
// In-order queue of outstanding gshare predictions: pops on branch resolution,
// drives the PHT update port and a redirect pulse on mispredict, keeps statistics.
`ifndef GHR_LEN
`define GHR_LEN 8
`endif

module bp_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int IDX_W = `GHR_LEN,
  parameter int PC_W  = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [IDX_W-1:0] push_index,
  input  logic             push_predict,
  input  logic [PC_W-1:0]  push_target,
  input  logic [PC_W-1:0]  push_fallthru,
  input  logic             res_valid,
  input  logic             res_take,
  input  logic [PC_W-1:0]  res_target,
  input  logic             flush,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count,
  output logic             upd_wen,
  output logic [IDX_W-1:0] upd_index,
  output logic             upd_take,
  output logic             redirect,
  output logic [PC_W-1:0]  redirect_pc,
  output logic             overflow,
  output logic             underflow,
  output logic [31:0]      br_cnt,
  output logic [31:0]      miss_cnt
);

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             predict;
    logic [PC_W-1:0]  target;
    logic [PC_W-1:0]  fallthru;
  } entry_t;

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  entry_t           mem_q [DEPTH];
  entry_t           head;
  entry_t           new_entry;

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             upd_wen_q, upd_wen_d;
  logic [IDX_W-1:0] upd_index_q, upd_index_d;
  logic             upd_take_q, upd_take_d;
  logic             redirect_q, redirect_d;
  logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic [31:0]      br_cnt_q, br_cnt_d;
  logic [31:0]      miss_cnt_q, miss_cnt_d;

  logic             pop;
  logic             mispredict;
  logic             has_room;
  logic             push_live;
  logic             push_ok;
  logic [PC_W-1:0]  correct_pc;

  assign head      = mem_q[rd_ptr_q];
  assign new_entry = '{index: push_index, predict: push_predict,
                       target: push_target, fallthru: push_fallthru};

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop        = res_valid && (count_q != '0) && !flush;
    mispredict = pop && ((head.predict != res_take) ||
                         (head.predict && res_take && (head.target != res_target)));
    correct_pc = res_take ? res_target : head.fallthru;
    // A pop that frees a slot lets a push into a full queue in the same cycle.
    has_room   = (count_q != FULL_CNT) || pop;
    // Pushes alongside a flush or a mispredict belong to the wrong path.
    push_live  = push && !flush && !mispredict;
    push_ok    = push_live && has_room;

    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    upd_wen_d     = pop;
    upd_index_d   = upd_index_q;
    upd_take_d    = upd_take_q;
    redirect_d    = mispredict;
    redirect_pc_d = redirect_pc_q;
    overflow_d    = overflow_q | (push_live && !has_room);
    underflow_d   = underflow_q | (res_valid && !flush && (count_q == '0));
    br_cnt_d      = br_cnt_q + 32'(pop);
    miss_cnt_d    = miss_cnt_q + 32'(mispredict);

    if (pop) begin
      upd_index_d = head.index;
      upd_take_d  = res_take;
    end
    if (mispredict) redirect_pc_d = correct_pc;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else if (mispredict) begin
      // Younger entries are all wrong-path: collapse the queue behind the popped head.
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
      count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      upd_wen_q     <= 1'b0;
      upd_index_q   <= '0;
      upd_take_q    <= 1'b0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      overflow_q    <= 1'b0;
      underflow_q   <= 1'b0;
      br_cnt_q      <= '0;
      miss_cnt_q    <= '0;
    end else begin
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      upd_wen_q     <= upd_wen_d;
      upd_index_q   <= upd_index_d;
      upd_take_q    <= upd_take_d;
      redirect_q    <= redirect_d;
      redirect_pc_q <= redirect_pc_d;
      overflow_q    <= overflow_d;
      underflow_q   <= underflow_d;
      br_cnt_q      <= br_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
    end
  end

  // NOTE: entry storage has no reset; the pointers and count define which slots hold live data.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= new_entry;
  end

  assign full        = (count_q == FULL_CNT);
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign upd_wen     = upd_wen_q;
  assign upd_index   = upd_index_q;
  assign upd_take    = upd_take_q;
  assign redirect    = redirect_q;
  assign redirect_pc = redirect_pc_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign br_cnt      = br_cnt_q;
  assign miss_cnt    = miss_cnt_q;

endmodule
